// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one Avalon-MM word read per fetch_en in IDLE and returns the word.
// One-cycle minimum bus latency; holds the request under waitrequest and stops for good on halt, misalignment or timeout.
module instr_fetch #(
  parameter logic [31:0] HALT_ADDR  = 32'h00000000,
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_en,
  input  logic [31:0] pc,
  input  logic        active_in,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic [3:0]  avm_byteenable,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        stall,
  output logic        fetch_err,
  output logic        halted
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_addr;
  logic        r_read;
  logic [31:0] r_instr;
  logic        r_instr_valid;
  logic        r_fetch_err;
  logic        r_halted;
  logic [7:0]  r_wait_cnt;

  logic [7:0]  w_wait_next;
  logic        w_timeout;
  logic        w_halt_req;
  logic        w_misaligned;

  // Counter saturates rather than wrapping so a large WAIT_LIMIT can never alias back to zero.
  assign w_wait_next  = (r_wait_cnt == 8'hFF) ? 8'hFF : r_wait_cnt + 8'd1;
  assign w_timeout    = ({24'd0, w_wait_next} >= WAIT_LIMIT);
  assign w_halt_req   = (pc == HALT_ADDR) || !active_in;
  assign w_misaligned = (pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_addr        <= 32'd0;
      r_read        <= 1'b0;
      r_instr       <= 32'd0;
      r_instr_valid <= 1'b0;
      r_fetch_err   <= 1'b0;
      r_halted      <= 1'b0;
      r_wait_cnt    <= 8'd0;
    end else begin
      r_instr_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (fetch_en) begin
            // Halt outranks misalignment, so a halting PC never raises fetch_err.
            if (w_halt_req) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end else if (w_misaligned) begin
              r_state     <= S_HALT;
              r_fetch_err <= 1'b1;
              r_halted    <= 1'b1;
            end else begin
              r_state    <= S_REQ;
              r_addr     <= pc;
              r_read     <= 1'b1;
              r_wait_cnt <= 8'd0;
            end
          end
        end
        S_REQ: begin
          if (!avm_waitrequest) begin
            r_instr       <= avm_readdata;
            r_read        <= 1'b0;
            r_instr_valid <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_wait_cnt <= w_wait_next;
            if (w_timeout) begin
              r_read      <= 1'b0;
              r_fetch_err <= 1'b1;
              r_halted    <= 1'b1;
              r_state     <= S_HALT;
            end
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign avm_address    = r_addr;
  assign avm_read       = r_read;
  assign avm_byteenable = r_read ? 4'b1111 : 4'b0000;
  assign instr          = r_instr;
  assign instr_valid    = r_instr_valid;
  assign stall          = (r_state == S_REQ);
  assign fetch_err      = r_fetch_err;
  assign halted         = r_halted;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: expected instruction words are queued at issue time and
// consumed by an independent monitor on every instr_valid pulse.
module tb_instr_fetch;

  logic        clk;
  logic        reset_n;
  logic        fetch_en;
  logic [31:0] pc;
  logic        active_in;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic [31:0] avm_address;
  logic        avm_read;
  logic [3:0]  avm_byteenable;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        fetch_err;
  logic        halted;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  instr_fetch #(
    .HALT_ADDR (32'h00000000),
    .WAIT_LIMIT(255)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .fetch_en       (fetch_en),
    .pc             (pc),
    .active_in      (active_in),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_byteenable (avm_byteenable),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .stall          (stall),
    .fetch_err      (fetch_err),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    fetch_en = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  // Monitor: every instr_valid pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (instr_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_instr_valid actual=%h required=no_pulse", instr);
        end else begin
          chk("instr_data", instr, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    reset_n         = 1'b0;
    fetch_en        = 1'b0;
    pc              = 32'h0;
    active_in       = 1'b1;
    avm_waitrequest = 1'b0;
    avm_readdata    = 32'h0;
    tick();
    tick();
    chk("rst_read",    {31'd0, avm_read},    32'd0);
    chk("rst_be",      {28'd0, avm_byteenable}, 32'd0);
    chk("rst_instr",   instr,                32'd0);
    chk("rst_valid",   {31'd0, instr_valid}, 32'd0);
    chk("rst_stall",   {31'd0, stall},       32'd0);
    chk("rst_err",     {31'd0, fetch_err},   32'd0);
    chk("rst_halted",  {31'd0, halted},      32'd0);
    reset_n = 1'b1;

    // Zero-wait fetch
    pc = 32'hBFC00000; avm_readdata = 32'h3C011234; avm_waitrequest = 1'b0; fetch_en = 1'b1;
    exp_q.push_back(32'h3C011234);
    tick();
    fetch_en = 1'b0;
    chk("f0_read",  {31'd0, avm_read}, 32'd1);
    chk("f0_addr",  avm_address,       32'hBFC00000);
    chk("f0_be",    {28'd0, avm_byteenable}, 32'hF);
    chk("f0_stall", {31'd0, stall},    32'd1);
    tick();
    chk("f0_read_drop",  {31'd0, avm_read}, 32'd0);
    chk("f0_stall_drop", {31'd0, stall},    32'd0);
    chk("f0_instr",      instr,             32'h3C011234);
    tick();
    chk("f0_valid_once", {31'd0, instr_valid}, 32'd0);
    chk("f0_retain",     instr,                32'h3C011234);

    // Three waitrequest cycles; garbage data and a new fetch_en during the stall must be ignored
    pc = 32'hBFC00004; avm_readdata = 32'hDEADBEEF; avm_waitrequest = 1'b1; fetch_en = 1'b1;
    exp_q.push_back(32'h8C220000);
    tick();
    pc = 32'h00001230;
    for (int i = 0; i < 4; i++) begin
      chk("f1_read_hold",  {31'd0, avm_read}, 32'd1);
      chk("f1_addr_hold",  avm_address,       32'hBFC00004);
      chk("f1_stall_hold", {31'd0, stall},    32'd1);
      if (i < 3) tick();
    end
    fetch_en = 1'b0; avm_waitrequest = 1'b0; avm_readdata = 32'h8C220000;
    tick();
    chk("f1_read_drop",  {31'd0, avm_read}, 32'd0);
    chk("f1_stall_drop", {31'd0, stall},    32'd0);
    tick();
    chk("f1_no_refetch", {31'd0, avm_read}, 32'd0);

    // Reset in the second cycle of a stalled request discards the read
    pc = 32'h00000100; avm_readdata = 32'h11111111; avm_waitrequest = 1'b1; fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    tick();
    reset_n = 1'b0; avm_waitrequest = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rr_read",  {31'd0, avm_read}, 32'd0);
    chk("rr_instr", instr,             32'd0);
    chk("rr_stall", {31'd0, stall},    32'd0);
    pc = 32'h00000200; avm_readdata = 32'h24020005; fetch_en = 1'b1;
    exp_q.push_back(32'h24020005);
    tick();
    fetch_en = 1'b0;
    chk("rr_new_addr", avm_address, 32'h00000200);
    tick();
    chk("rr_new_instr", instr, 32'h24020005);
    tick();

    // Misaligned PC: error and halt, no bus read; HALT is terminal
    pc = 32'hBFC00002; fetch_en = 1'b1;
    tick();
    chk("mis_err",    {31'd0, fetch_err}, 32'd1);
    chk("mis_halted", {31'd0, halted},    32'd1);
    chk("mis_read",   {31'd0, avm_read},  32'd0);
    pc = 32'hBFC00000;
    tick();
    tick();
    chk("mis_terminal_read",  {31'd0, avm_read}, 32'd0);
    chk("mis_terminal_stall", {31'd0, stall},    32'd0);
    do_reset();

    // Halt address
    pc = 32'h00000000; fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    chk("halt_halted", {31'd0, halted},    32'd1);
    chk("halt_err",    {31'd0, fetch_err}, 32'd0);
    chk("halt_read",   {31'd0, avm_read},  32'd0);
    do_reset();

    // Inactive CPU with a misaligned PC: halt wins, no error
    active_in = 1'b0; pc = 32'hBFC00002; fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0; active_in = 1'b1;
    chk("inact_halted", {31'd0, halted},    32'd1);
    chk("inact_err",    {31'd0, fetch_err}, 32'd0);
    chk("inact_read",   {31'd0, avm_read},  32'd0);
    do_reset();

    // Bus timeout after 255 waitrequest cycles
    pc = 32'h00000400; avm_waitrequest = 1'b1; fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    for (int i = 0; i < 254; i++) tick();
    chk("to_still_req",   {31'd0, stall},  32'd1);
    chk("to_not_halted",  {31'd0, halted}, 32'd0);
    tick();
    chk("to_err",    {31'd0, fetch_err}, 32'd1);
    chk("to_halted", {31'd0, halted},    32'd1);
    chk("to_read",   {31'd0, avm_read},  32'd0);
    chk("to_stall",  {31'd0, stall},     32'd0);
    avm_waitrequest = 1'b0; pc = 32'h00000800; fetch_en = 1'b1;
    tick();
    tick();
    fetch_en = 1'b0;
    chk("to_ignore_read", {31'd0, avm_read}, 32'd0);
    chk("to_ignore_addr", avm_address,       32'h00000400);

    tick();
    chk("pending_expectations", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
